// File: rtl/ps2_kbd_ctrl.sv
// Host-side PS/2 keyboard controller: paced FIFO fetch into a one-byte output buffer,
// level IRQ, status/control port and a timed receiver reset to clear sticky errors.
module ps2_kbd_ctrl #(
  parameter int RX_RESET_CYCLES = 4
) (
  input  logic       busclk,
  input  logic       rst,
  input  logic       cs,
  input  logic       addr,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  output logic       rx_rstn,
  output logic       rx_pop,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  input  logic       rx_frame_error,
  input  logic       rx_parity_error,
  input  logic       rx_overflow
);

  localparam int CW = $clog2(RX_RESET_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, COOL, RXRST} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    obuf_reg;
  logic          obf_reg;
  logic          irq_en_reg;
  logic          kbd_dis_reg;
  logic          rx_release_reg;

  logic data_rd;
  logic ctrl_wr;
  logic err_clr;
  logic capture;
  logic rx_resetting;
  logic unused_wdata;

  assign data_rd      = cs & rd & ~addr;
  assign ctrl_wr      = cs & wr & addr;
  assign err_clr      = ctrl_wr & wdata[7];
  assign capture      = (state_reg == CAPTURE);
  assign rx_resetting = (state_reg == RXRST);
  assign unused_wdata = ^wdata[6:2];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE:    if (!obf_reg && !kbd_dis_reg && !rx_empty) state_next = SETTLE;
      SETTLE:  state_next = CAPTURE;
      CAPTURE: state_next = COOL;
      COOL:    state_next = IDLE;
      RXRST: begin
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // An error-clear overrides everything, including a restart while already resetting.
    if (err_clr) begin
      state_next = RXRST;
      cnt_next   = CW'(RX_RESET_CYCLES - 1);
    end
  end

  always_ff @(posedge busclk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      obuf_reg       <= 8'h00;
      obf_reg        <= 1'b0;
      irq_en_reg     <= 1'b0;
      kbd_dis_reg    <= 1'b0;
      rx_release_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      rx_release_reg <= 1'b1;
      // A capture needs OBF=0, so it never collides with a data-port read.
      if (capture) begin
        obuf_reg <= rx_data;
        obf_reg  <= 1'b1;
      end else if (data_rd) begin
        obf_reg <= 1'b0;
      end
      if (ctrl_wr) begin
        irq_en_reg  <= wdata[0];
        kbd_dis_reg <= wdata[1];
      end
    end
  end

  assign rx_pop  = capture;
  assign rx_rstn = rx_release_reg & ~rx_resetting;
  assign irq     = obf_reg & irq_en_reg;
  assign rdata   = addr ? {rx_resetting, 1'b0, rx_overflow, rx_parity_error, rx_frame_error,
                           kbd_dis_reg, irq_en_reg, obf_reg}
                        : obuf_reg;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: behavioural receiver FIFO with a late fifo_top,
// and a scoreboard of bytes pushed to the receiver versus bytes read from the data port.
module tb_ps2_kbd_ctrl;

  logic       busclk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0;
  logic       addr = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       irq;
  logic       rx_rstn;
  logic       rx_pop;
  logic [7:0] rx_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       rx_frame_error = 1'b0;
  logic       rx_parity_error = 1'b0;
  logic       rx_overflow = 1'b0;

  ps2_kbd_ctrl #(.RX_RESET_CYCLES(4)) dut (
    .busclk(busclk), .rst(rst), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .wdata(wdata), .rdata(rdata), .irq(irq), .rx_rstn(rx_rstn), .rx_pop(rx_pop),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_frame_error(rx_frame_error),
    .rx_parity_error(rx_parity_error), .rx_overflow(rx_overflow)
  );

  always #5 busclk = ~busclk;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] top_d = 8'h00;

  // Receiver model: rx_empty follows the queue one edge later, fifo_top one edge after that.
  always @(posedge busclk) begin
    if (!rx_rstn) begin
      fifo_q.delete();
      rx_empty <= 1'b1;
      top_d    <= 8'h00;
      rx_data  <= 8'h00;
    end else begin
      if (rx_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      rx_empty <= (fifo_q.size() == 0);
      top_d    <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      rx_data  <= top_d;
    end
  end

  int  ncyc = 0;
  int  fall_t = 0;
  int  pop_t = 0;
  int  pop_cnt = 0;
  int  bad_pops = 0;
  int  low_cnt = 0;
  logic empty_d = 1'b1;

  always @(negedge busclk) begin
    ncyc    <= ncyc + 1;
    empty_d <= rx_empty;
    if (empty_d && !rx_empty) fall_t <= ncyc;
    if (rx_pop) begin
      pop_cnt <= pop_cnt + 1;
      pop_t   <= ncyc;
      if (rx_empty) bad_pops <= bad_pops + 1;
    end
    if (!rx_rstn && !rst) low_cnt <= low_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic bus_read(input logic a, output logic [7:0] d);
    @(negedge busclk);
    cs = 1'b1; rd = 1'b1; addr = a;
    #1 d = rdata;
    @(posedge busclk);
    #1 cs = 1'b0; rd = 1'b0;
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    @(negedge busclk);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge busclk);
    #1 cs = 1'b0; wr = 1'b0;
    $display("wr addr%0d <= 0x%02h", a, d);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge busclk);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic read_data(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    bus_read(1'b0, d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    $display("rd data 0x%02h", d);
    check(tag, {8'h00, d}, {8'h00, e});
  endtask

  task automatic read_status(input string tag, input logic [7:0] e);
    logic [7:0] s;
    bus_read(1'b1, s);
    $display("rd status 0x%02h", s);
    check(tag, {8'h00, s}, {8'h00, e});
  endtask

  task automatic wait_obf(input string tag);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 100; i++) begin
      bus_read(1'b1, s);
      if (s[0]) break;
    end
    check(tag, {15'h0, s[0]}, 16'h1);
  endtask

  task automatic wait_rstn_high(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (rx_rstn) break;
      @(negedge busclk);
    end
    check(tag, {15'h0, rx_rstn}, 16'h1);
  endtask

  int pop_base;
  int low_base;

  initial begin
    // Reset state
    #1;
    check("rst_rx_rstn", {15'h0, rx_rstn}, 16'h0);
    check("rst_rx_pop", {15'h0, rx_pop}, 16'h0);
    check("rst_irq", {15'h0, irq}, 16'h0);
    repeat (2) @(negedge busclk);
    rst = 1'b0;
    @(posedge busclk);
    #1 check("rx_rstn_released", {15'h0, rx_rstn}, 16'h1);
    read_status("status_reset", 8'h00);

    // Single byte with interrupts enabled
    bus_write(1'b1, 8'h01);
    pop_base = pop_cnt;
    push_byte(8'h1C);
    wait_obf("obf_1c");
    check("pop_latency", 16'(pop_t - fall_t), 16'd2);
    check("irq_set", {15'h0, irq}, 16'h1);
    read_status("status_obf", 8'h03);
    read_data("data_1c");
    check("irq_drop", {15'h0, irq}, 16'h0);
    read_status("status_after_read", 8'h02);
    check("pops_1c", 16'(pop_cnt - pop_base), 16'd1);

    // Two queued bytes, slow host
    pop_base = pop_cnt;
    push_byte(8'hF0);
    push_byte(8'h1C);
    wait_obf("obf_f0");
    repeat (20) @(negedge busclk);
    check("pops_held", 16'(pop_cnt - pop_base), 16'd1);
    read_data("data_f0");
    wait_obf("obf_1c_2");
    read_data("data_1c_2");
    check("pops_two", 16'(pop_cnt - pop_base), 16'd2);

    // Keyboard disabled blocks fetch
    bus_write(1'b1, 8'h02);
    pop_base = pop_cnt;
    push_byte(8'h5A);
    repeat (20) @(negedge busclk);
    check("pops_disabled", 16'(pop_cnt - pop_base), 16'd0);
    read_status("status_disabled", 8'h04);
    bus_write(1'b1, 8'h00);
    wait_obf("obf_5a");
    read_data("data_5a");

    // Error flags and error-clear with a full buffer
    bus_write(1'b1, 8'h01);
    push_byte(8'h33);
    wait_obf("obf_33");
    check("irq_33", {15'h0, irq}, 16'h1);
    rx_parity_error = 1'b1;
    rx_overflow = 1'b1;
    read_status("status_errors", 8'h33);
    low_base = low_cnt;
    bus_write(1'b1, 8'h80);
    check("rxrst_active", {15'h0, rx_rstn}, 16'h0);
    addr = 1'b1;
    #1 check("status_bit7", {15'h0, rdata[7]}, 16'h1);
    rx_parity_error = 1'b0;
    rx_overflow = 1'b0;
    wait_rstn_high("rxrst_end");
    check("rxrst_len", 16'(low_cnt - low_base), 16'd4);
    read_status("status_cleared", 8'h01);
    check("irq_after_clear", {15'h0, irq}, 16'h0);
    read_data("data_33");

    // Error-clear landing on the capture cycle
    pop_base = pop_cnt;
    push_byte(8'h66);
    for (int i = 0; i < 50; i++) begin
      @(negedge busclk);
      if (rx_pop) break;
    end
    check("capture_seen", {15'h0, rx_pop}, 16'h1);
    cs = 1'b1; wr = 1'b1; addr = 1'b1; wdata = 8'h80;
    @(posedge busclk);
    #1 cs = 1'b0; wr = 1'b0;
    $display("wr addr1 <= 0x80 (capture cycle)");
    check("status_capture_clr", {8'h00, rdata}, 16'h0081);
    wait_rstn_high("rxrst_end_2");
    repeat (10) @(negedge busclk);
    check("pops_capture_clr", 16'(pop_cnt - pop_base), 16'd1);
    read_data("data_66");

    // Asynchronous reset during SETTLE
    pop_base = pop_cnt;
    push_byte(8'h77);
    for (int i = 0; i < 50; i++) begin
      @(negedge busclk);
      if (!rx_empty) break;
    end
    @(negedge busclk);
    rst = 1'b1;
    #1;
    check("arst_rx_rstn", {15'h0, rx_rstn}, 16'h0);
    check("arst_rx_pop", {15'h0, rx_pop}, 16'h0);
    check("arst_irq", {15'h0, irq}, 16'h0);
    addr = 1'b1;
    #1 check("arst_status", {8'h00, rdata}, 16'h0000);
    addr = 1'b0;
    #1 check("arst_obuf", {8'h00, rdata}, 16'h0000);
    void'(exp_q.pop_back());
    repeat (3) @(negedge busclk);
    rst = 1'b0;
    check("arst_no_pop", 16'(pop_cnt - pop_base), 16'd0);
    @(posedge busclk);
    push_byte(8'h29);
    wait_obf("obf_29");
    read_data("data_29");

    check("no_pop_when_empty", 16'(bad_pops), 16'd0);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
